// File: rtl/iic_pkg.sv
// Shared types and constants for the I2C register-write sequencer and its timers.
package iic_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEND   = 3'd1,
    WAIT   = 3'd2,
    GAP    = 3'd3,
    FINISH = 3'd4,
    FAIL   = 3'd5
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_NACK    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  localparam logic [1:0] BYTE_DEV = 2'd0;
  localparam logic [1:0] BYTE_REG = 2'd1;
  localparam logic [1:0] BYTE_DAT = 2'd2;

  localparam logic WR_BIT = 1'b0;

  // Counter width able to hold 0..n; never narrower than one bit.
  function automatic int counter_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/iic_cycle_timer.sv
// Saturating cycle counter: clear wins over count, term flags the last cycle of a TERM_CYC window.
module iic_cycle_timer
  import iic_pkg::*;
#(
  parameter int TERM_CYC = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic term
);

  localparam int W = counter_width(TERM_CYC);
  localparam logic [W-1:0] LAST = W'(TERM_CYC - 1);

  logic [W-1:0] count;

  // Count while enabled, holding at LAST instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && (count != LAST)) begin
      count <= count + W'(1);
    end
  end

  assign term = (count == LAST);

endmodule

// File: rtl/iic_reg_write_ctrl.sv
// Sequences one I2C register write (device, register, data byte) on a byte-level write engine,
// retrying the whole transaction on NACK and aborting on engine timeout.
module iic_reg_write_ctrl
  import iic_pkg::*;
#(
  parameter int TIMEOUT_CYC = 2000,
  parameter int MAX_RETRY   = 3,
  parameter int GAP_CYC     = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [6:0] dev_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wr_data,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code,
  output logic       byte_start,
  output logic [7:0] byte_data,
  output logic       byte_first,
  output logic       byte_last,
  input  logic       byte_done,
  input  logic       byte_nack
);

  localparam int RW = counter_width(MAX_RETRY);
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

  state_t        state, state_nxt;
  logic [1:0]    idx, idx_nxt;
  logic [RW-1:0] retry, retry_nxt;
  logic [6:0]    dev_l;
  logic [7:0]    reg_l, dat_l;
  logic          accept, load_byte;
  logic          busy_nxt, done_nxt, err_nxt, start_nxt;
  logic [1:0]    err_code_nxt;
  logic [7:0]    mux_data;
  logic          to_clear, to_en, to_term;
  logic          gap_clear, gap_en, gap_term;

  // The timeout window opens on the byte_start cycle itself, so SEND counts too.
  assign to_en  = (state == SEND) || (state == WAIT);
  assign gap_en = (state == GAP);

  iic_cycle_timer #(.TERM_CYC(TIMEOUT_CYC)) u_timeout (
    .clk(clk), .rst(rst), .clear(to_clear), .en(to_en), .term(to_term)
  );

  iic_cycle_timer #(.TERM_CYC(GAP_CYC)) u_gap (
    .clk(clk), .rst(rst), .clear(gap_clear), .en(gap_en), .term(gap_term)
  );

  // Next-state and next-output logic of the transaction sequencer.
  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    retry_nxt    = retry;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    err_nxt      = 1'b0;
    err_code_nxt = err_code;
    start_nxt    = 1'b0;
    accept       = 1'b0;
    load_byte    = 1'b0;
    to_clear     = 1'b0;
    gap_clear    = 1'b0;

    case (state)
      IDLE, FINISH, FAIL: begin
        if (req) begin
          accept       = 1'b1;
          load_byte    = 1'b1;
          to_clear     = 1'b1;
          start_nxt    = 1'b1;
          busy_nxt     = 1'b1;
          idx_nxt      = BYTE_DEV;
          retry_nxt    = '0;
          err_code_nxt = ERR_NONE;
          state_nxt    = SEND;
        end else begin
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end
      SEND: begin
        state_nxt = WAIT;
      end
      WAIT: begin
        if (byte_done) begin
          if (!byte_nack) begin
            if (idx == BYTE_DAT) begin
              done_nxt  = 1'b1;
              busy_nxt  = 1'b0;
              state_nxt = FINISH;
            end else begin
              idx_nxt   = idx + 2'd1;
              load_byte = 1'b1;
              to_clear  = 1'b1;
              start_nxt = 1'b1;
              state_nxt = SEND;
            end
          end else if (retry < RETRY_LIMIT) begin
            retry_nxt = retry + RW'(1);
            gap_clear = 1'b1;
            state_nxt = GAP;
          end else begin
            err_nxt      = 1'b1;
            err_code_nxt = ERR_NACK;
            busy_nxt     = 1'b0;
            state_nxt    = FAIL;
          end
        end else if (to_term) begin
          err_nxt      = 1'b1;
          err_code_nxt = ERR_TIMEOUT;
          busy_nxt     = 1'b0;
          state_nxt    = FAIL;
        end else begin
          state_nxt = WAIT;
        end
      end
      GAP: begin
        if (gap_term) begin
          idx_nxt   = BYTE_DEV;
          load_byte = 1'b1;
          to_clear  = 1'b1;
          start_nxt = 1'b1;
          state_nxt = SEND;
        end else begin
          state_nxt = GAP;
        end
      end
      default: begin
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Byte mux; on accept the address comes straight from the port since the latch is not loaded yet.
  always_comb begin
    case (idx_nxt)
      BYTE_DEV: mux_data = {(accept ? dev_addr : dev_l), WR_BIT};
      BYTE_REG: mux_data = reg_l;
      BYTE_DAT: mux_data = dat_l;
      default:  mux_data = 8'h00;
    endcase
  end

  // State, latched fields and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= BYTE_DEV;
      retry      <= '0;
      dev_l      <= 7'h00;
      reg_l      <= 8'h00;
      dat_l      <= 8'h00;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_code   <= ERR_NONE;
      byte_start <= 1'b0;
      byte_data  <= 8'h00;
      byte_first <= 1'b0;
      byte_last  <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      retry      <= retry_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      err        <= err_nxt;
      err_code   <= err_code_nxt;
      byte_start <= start_nxt;
      if (accept) begin
        dev_l <= dev_addr;
        reg_l <= reg_addr;
        dat_l <= wr_data;
      end
      if (load_byte) begin
        byte_data  <= mux_data;
        byte_first <= (idx_nxt == BYTE_DEV);
        byte_last  <= (idx_nxt == BYTE_DAT);
      end
    end
  end

endmodule

// File: tb/tb_iic_reg_write_ctrl.sv
// Scoreboard bench for iic_reg_write_ctrl: a reference model queues expected events and cycles,
// an engine model answers bytes, and a monitor compares every DUT event against the queues.
module tb_iic_reg_write_ctrl;

  localparam int TIMEOUT_CYC = 2000;
  localparam int MAX_RETRY   = 3;
  localparam int GAP_CYC     = 10;

  typedef struct {
    int         kind;   // 0 byte, 1 done, 2 err
    logic [7:0] data;
    logic       first;
    logic       last;
    logic [1:0] code;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst, req, byte_done, byte_nack;
  logic [6:0] dev_addr;
  logic [7:0] reg_addr, wr_data;
  logic       busy, done, err, byte_start, byte_first, byte_last;
  logic [1:0] err_code;
  logic [7:0] byte_data;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  ev_t  exp_q[$];
  int   exp_cyc[$];
  logic [1:0] exp_code;

  // transaction plan shared with the engine model
  int p_type, p_k, p_n, p_dly, txn_id, spur_tok;
  // engine model state
  int e_idx, e_att, seen_id, spur_seen, resp_at;
  logic pending, resp_nack;

  iic_reg_write_ctrl #(
    .TIMEOUT_CYC(TIMEOUT_CYC), .MAX_RETRY(MAX_RETRY), .GAP_CYC(GAP_CYC)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .dev_addr(dev_addr), .reg_addr(reg_addr),
    .wr_data(wr_data), .busy(busy), .done(done), .err(err), .err_code(err_code),
    .byte_start(byte_start), .byte_data(byte_data), .byte_first(byte_first),
    .byte_last(byte_last), .byte_done(byte_done), .byte_nack(byte_nack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_byte(input logic [7:0] d, input int i);
    ev_t e;
    e.kind = 0; e.data = d; e.first = (i == 0); e.last = (i == 2); e.code = 2'b00;
    exp_q.push_back(e);
  endtask

  task automatic push_end(input int kind, input logic [1:0] code);
    ev_t e;
    e.kind = kind; e.data = 8'h00; e.first = 1'b0; e.last = 1'b0; e.code = code;
    exp_q.push_back(e);
    exp_code = code;
  endtask

  // Reference model: whole-transaction attempts, each NACK restarting from the device byte.
  task automatic issue(input logic [6:0] d, input logic [7:0] r, input logic [7:0] w,
                       input int pt, input int pk, input int pn, input int pd);
    logic [7:0] b [3];
    b[0] = {d, 1'b0}; b[1] = r; b[2] = w;
    dev_addr = d; reg_addr = r; wr_data = w;
    p_type = pt; p_k = pk; p_n = pn; p_dly = pd; txn_id++;
    if (pt == 2) begin
      for (int i = 0; i <= pk; i++) push_byte(b[i], i);
      push_end(2, 2'b10);
    end else begin
      for (int a = 0; a <= MAX_RETRY; a++) begin
        if (pt == 1 && a < pn) begin
          for (int i = 0; i <= pk; i++) push_byte(b[i], i);
          if (a == MAX_RETRY) push_end(2, 2'b01);
        end else begin
          for (int i = 0; i < 3; i++) push_byte(b[i], i);
          push_end(1, 2'b00);
          break;
        end
      end
    end
    exp_cyc.push_back(cyc + 1);
  endtask

  task automatic go(input logic [6:0] d, input logic [7:0] r, input logic [7:0] w,
                    input int pt, input int pk, input int pn, input int pd);
    issue(d, r, w, pt, pk, pn, pd);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int t = 0;
    while ((exp_q.size() != 0 || busy) && t < budget) begin
      @(negedge clk);
      t++;
    end
    if (t >= budget) begin
      n_chk++; n_fail++;
      $display("FAIL txn_budget: %0d events still pending after %0d cycles", exp_q.size(), budget);
      exp_q.delete(); exp_cyc.delete();
    end
    repeat (3) @(negedge clk);
    chk("err_code_held", err_code, exp_code);
  endtask

  // Engine model: answers each byte after p_dly cycles, NACKs or stalls according to the plan.
  initial begin
    byte_done = 1'b0; byte_nack = 1'b0; pending = 1'b0; resp_nack = 1'b0;
    e_idx = 0; e_att = 0; seen_id = 0; spur_seen = 0; resp_at = 0;
    forever begin
      @(negedge clk);
      byte_done = 1'b0;
      byte_nack = 1'($urandom_range(0, 1));
      if (rst) begin
        pending = 1'b0;
      end else begin
        if (seen_id != txn_id) begin
          seen_id = txn_id; e_idx = 0; e_att = 0;
        end
        if (byte_start) begin
          if (p_type == 2 && e_idx == p_k) begin
            exp_cyc.push_back(cyc + TIMEOUT_CYC);
          end else begin
            pending   = 1'b1;
            resp_at   = cyc + p_dly;
            resp_nack = (p_type == 1 && e_att < p_n && e_idx == p_k);
          end
          e_idx++;
        end
        if (pending && cyc == resp_at) begin
          byte_done = 1'b1;
          byte_nack = resp_nack;
          pending   = 1'b0;
          if (resp_nack) begin
            exp_cyc.push_back(cyc + 1 + ((e_att < MAX_RETRY) ? GAP_CYC : 0));
            e_att++;
            e_idx = 0;
          end else begin
            exp_cyc.push_back(cyc + 1);
          end
        end else if (!pending && spur_tok != spur_seen) begin
          spur_seen = spur_tok;
          byte_done = 1'b1;
        end
      end
    end
  end

  // Monitor: pops and compares one expected event whenever the DUT presents one.
  initial begin
    ev_t e;
    int  c, kind;
    forever begin
      @(negedge clk);
      if (!rst && (byte_start || done || err)) begin
        kind = byte_start ? 0 : (done ? 1 : 2);
        if (done && err) begin
          n_chk++; n_fail++;
          $display("FAIL done_err_exclusive: both asserted at cycle %0d", cyc);
        end
        if (exp_q.size() == 0 || exp_cyc.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_event: kind %0d at cycle %0d with nothing expected", kind, cyc);
        end else begin
          e = exp_q.pop_front();
          c = exp_cyc.pop_front();
          chk("event_kind", kind, e.kind);
          chk("event_cycle", cyc, c);
          chk("busy_at_event", {31'd0, busy}, (kind == 0) ? 1 : 0);
          chk("err_code_at_event", {30'd0, err_code}, (kind == 2) ? {30'd0, e.code} : 0);
          if (kind == 0) chk("byte_fields", {byte_data, byte_first, byte_last}, {e.data, e.first, e.last});
        end
      end
    end
  end

  initial begin
    int t;
    rst = 1'b1; req = 1'b0; dev_addr = 7'h00; reg_addr = 8'h00; wr_data = 8'h00;
    p_type = 0; p_k = 0; p_n = 0; p_dly = 1; txn_id = 0; spur_tok = 0; exp_code = 2'b00;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {busy, done, err, err_code, byte_start, byte_data, byte_first, byte_last}, 0);
    rst = 1'b0;
    @(negedge clk);

    // basic write, 50-cycle ACKs
    go(7'h3C, 8'h12, 8'hA5, 0, 0, 0, 50);
    wait_idle(6000);
    // NACK on register byte once, then success
    go(7'h51, 8'h07, 8'h3E, 1, 1, 1, 20);
    wait_idle(6000);
    // NACK every attempt
    go(7'h2A, 8'hC3, 8'h99, 1, 2, MAX_RETRY + 1, 15);
    wait_idle(6000);
    // engine never answers
    go(7'h10, 8'h20, 8'h30, 2, 0, 0, 1);
    wait_idle(6000);

    // req and fields wiggle while busy
    go(7'h66, 8'h44, 8'h22, 0, 0, 0, 50);
    for (int i = 0; i < 30; i++) begin
      req = 1'($urandom_range(0, 1));
      dev_addr = 7'($urandom); reg_addr = 8'($urandom); wr_data = 8'($urandom);
      @(negedge clk);
    end
    req = 1'b0;
    wait_idle(6000);

    // reset while waiting on the register byte
    go(7'h3C, 8'h12, 8'hA5, 0, 0, 0, 40);
    t = 0;
    while (!(e_idx == 2 && pending) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("reached_wait_idx1", {31'd0, (e_idx == 2 && pending)}, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("async_reset_outputs", {busy, done, err, err_code, byte_start, byte_data, byte_first, byte_last}, 0);
    repeat (3) @(negedge clk);
    exp_q.delete(); exp_cyc.delete();
    rst = 1'b0; exp_code = 2'b00;
    repeat (5) @(negedge clk);
    chk("post_reset_idle", {busy, err_code}, 0);
    go(7'h3C, 8'h12, 8'hA5, 0, 0, 0, 5);
    wait_idle(6000);

    // stray byte_done while idle must be ignored
    spur_tok++;
    repeat (5) @(negedge clk);
    chk("spurious_done_idle", {busy, err_code}, {1'b0, exp_code});

    // req held high through done starts the next transaction immediately
    issue(7'h0F, 8'hF0, 8'h5A, 0, 0, 0, 7);
    req = 1'b1;
    @(negedge clk);
    dev_addr = 7'h71; reg_addr = 8'h8E; wr_data = 8'hC4;
    t = 0;
    while (!(done || err) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("b2b_first_end", {31'd0, (done || err)}, 1);
    issue(7'h71, 8'h8E, 8'hC4, 1, 0, 1, 9);
    @(negedge clk);
    req = 1'b0;
    wait_idle(6000);

    // randomized plans
    for (int n = 0; n < 14; n++) begin
      int sel, pt;
      sel = $urandom_range(0, 9);
      pt  = (sel < 6) ? 0 : ((sel < 9) ? 1 : 2);
      go(7'($urandom), 8'($urandom), 8'($urandom), pt, $urandom_range(0, 2),
         $urandom_range(1, MAX_RETRY + 1), $urandom_range(1, 30));
      wait_idle(6000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
